// File: rtl/led_pwm_fader.sv
// led_pwm_fader: three-channel PWM brightness engine for the tri-colour status LED.
// Brightness commands set a per-channel target. A command either jumps the
// current level to the target at once, or lets it ramp toward the target by
// one level per fade tick. The current levels drive 256-slot PWM comparators,
// and the comparator results are registered onto the pins.
module led_pwm_fader #(
    parameter int         CLK_FREQ = 20000000,
    parameter int         PWM_DIV  = 4,
    parameter int         FADE_DIV = 78125,
    parameter logic [2:0] INV_MASK = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_color,
    input  logic [7:0] cmd_level,
    input  logic       cmd_fade,
    output logic       busy,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue
);

    // A divider of 1 still needs a one-bit register.
    // That register stays at 0, so the wrap fires on every clock.
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
    localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

    // CLK_FREQ only documents the intended clock.
    // It is sanity-checked here and is not used in any arithmetic.
    if (CLK_FREQ < 1 || PWM_DIV < 1 || FADE_DIV < 1) begin : g_bad_param
        $error("led_pwm_fader: CLK_FREQ, PWM_DIV and FADE_DIV must be positive");
    end

    logic [PW-1:0]     pwm_presc;
    logic [7:0]        pwm_cnt;
    logic [FW-1:0]     fade_presc;
    logic              pwm_wrap;
    logic              fade_tick;
    logic              cmd_fire;
    logic [2:0]        cmd_sel;
    logic [2:0][7:0]   cur;
    logic [2:0][7:0]   tgt;
    logic [2:0]        differ;
    logic [2:0]        pwm_on;
    logic [2:0]        led_q;

    assign pwm_wrap  = (pwm_presc == PWM_LAST);
    assign fade_tick = (fade_presc == FADE_LAST);
    assign cmd_fire  = cmd_valid & cmd_ready;

    // Ready comes up on the first edge after reset is released.
    // Commands held during reset are therefore ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
        end
    end

    // PWM slot prescaler and 8-bit slot counter; both wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_presc <= '0;
            pwm_cnt   <= 8'd0;
        end else begin
            if (pwm_wrap) begin
                pwm_presc <= '0;
                pwm_cnt   <= pwm_cnt + 8'd1;
            end else begin
                pwm_presc <= pwm_presc + 1'b1;
            end
        end
    end

    // Fade prescaler.
    // Its wrap cycle is the fade tick, so one level step happens per FADE_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_presc <= '0;
        end else if (fade_tick) begin
            fade_presc <= '0;
        end else begin
            fade_presc <= fade_presc + 1'b1;
        end
    end

    // Decode the colour field into a channel mask; code 3 addresses all channels.
    always_comb begin
        cmd_sel = 3'b000;
        case (cmd_color)
            2'd0:    cmd_sel = 3'b001;
            2'd1:    cmd_sel = 3'b010;
            2'd2:    cmd_sel = 3'b100;
            default: cmd_sel = 3'b111;
        endcase
    end

    // Per-channel target/current update.
    // A command to a channel takes priority over that channel's fade step in the same cycle.
    // Steps only move toward the target, so the level cannot overshoot or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
            tgt <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (cmd_fire && cmd_sel[c]) begin
                    tgt[c] <= cmd_level;
                    if (!cmd_fade) begin
                        cur[c] <= cmd_level;
                    end
                end else if (fade_tick) begin
                    if (cur[c] < tgt[c]) begin
                        cur[c] <= cur[c] + 8'd1;
                    end else if (cur[c] > tgt[c]) begin
                        cur[c] <= cur[c] - 8'd1;
                    end
                end
            end
        end
    end

    // Per-channel comparisons for busy and PWM on-state, from registered levels only.
    always_comb begin
        differ = 3'b000;
        pwm_on = 3'b000;
        for (int c = 0; c < 3; c++) begin
            differ[c] = (cur[c] != tgt[c]);
            pwm_on[c] = (cur[c] > pwm_cnt);
        end
    end

    assign busy = |differ;

    // Registered pin drivers with polarity applied.
    // Reset parks every pin at its off level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= INV_MASK;
        end else begin
            led_q <= pwm_on ^ INV_MASK;
        end
    end

    assign led_red   = led_q[0];
    assign led_green = led_q[1];
    assign led_blue  = led_q[2];

endmodule

// File: tb/tb_led_pwm_fader.sv
// Testbench for led_pwm_fader.
// It uses a fast PWM (one slot per clock), a short fade divider and mixed output polarity.
`timescale 1ns/1ps
module tb_led_pwm_fader;

    localparam logic [2:0] INV = 3'b011;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_color;
    logic [7:0] cmd_level;
    logic       cmd_fade;
    logic       busy;
    logic       led_red;
    logic       led_green;
    logic       led_blue;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_q[$];
    int cyc;

    led_pwm_fader #(
        .CLK_FREQ(20000000),
        .PWM_DIV (1),
        .FADE_DIV(4),
        .INV_MASK(INV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_color(cmd_color),
        .cmd_level(cmd_level),
        .cmd_fade (cmd_fade),
        .busy     (busy),
        .led_red  (led_red),
        .led_green(led_green),
        .led_blue (led_blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release.
    // The edge numbered k is a fade tick when k % 4 == 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Fade ticks on edges in the range (a, b].
    function automatic int ticks(input int a, input int b);
        return b / 4 - a / 4;
    endfunction

    // Present one command for one edge; returns at the negedge after it is accepted.
    task automatic send(input logic [1:0] color, input logic [7:0] level, input logic fade);
        cmd_valid = 1'b1;
        cmd_color = color;
        cmd_level = level;
        cmd_fade  = fade;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Count logical on-slots per channel over one PWM period.
    // Also count samples where red/green are not the inverse of blue.
    task automatic measure(output int n_r, output int n_g, output int n_b, output int n_inv);
        n_r = 0; n_g = 0; n_b = 0; n_inv = 0;
        for (int i = 0; i < 256; i++) begin
            if ((led_red   ^ INV[0]) == 1'b1) n_r++;
            if ((led_green ^ INV[1]) == 1'b1) n_g++;
            if ((led_blue  ^ INV[2]) == 1'b1) n_b++;
            if (led_red !== ~led_blue || led_green !== ~led_blue) n_inv++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_color = 2'd0; cmd_level = 8'd0; cmd_fade = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(int'(INV)); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if ({led_blue, led_green, led_red} !== 3'(e)) begin err_cnt++;
            $display("FAIL reset_pins: got %b expected %b", {led_blue, led_green, led_red}, 3'(e)); end
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL reset_busy: got %b expected %0d", busy, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (cmd_ready !== 1'(e)) begin err_cnt++; $display("FAIL reset_ready: got %b expected %0d", cmd_ready, e); end
        // Release reset with a command already waiting; it must not be accepted.
        rst_n = 1'b1; cmd_valid = 1'b1; cmd_color = 2'd0; cmd_level = 8'd99; cmd_fade = 1'b0;
        #1;
        exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if (cmd_ready !== 1'(e)) begin err_cnt++; $display("FAIL ready_before_edge: got %b expected %0d", cmd_ready, e); end
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if (cmd_ready !== 1'(e)) begin err_cnt++; $display("FAIL ready_after_edge: got %b expected %0d", cmd_ready, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[0]) !== e) begin err_cnt++; $display("FAIL early_cmd_cur: got %0d expected %0d", dut.cur[0], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.tgt[0]) !== e) begin err_cnt++; $display("FAIL early_cmd_tgt: got %0d expected %0d", dut.tgt[0], e); end
    endtask

    task automatic test_immediate();
        int n_r, n_g, n_b, n_inv, e;
        logic [7:0] lv [3];
        lv[0] = 8'd64; lv[1] = 8'd0; lv[2] = 8'd255;
        for (int k = 0; k < 3; k++) begin
            send(2'd0, lv[k], 1'b0);
            @(negedge clk);
            exp_q.push_back(int'(lv[k])); exp_q.push_back(0); exp_q.push_back(0);
            measure(n_r, n_g, n_b, n_inv);
            e = exp_q.pop_front(); vec_cnt++;
            if (n_r !== e) begin err_cnt++; $display("FAIL imm_red_lvl%0d: got %0d on-slots expected %0d", lv[k], n_r, e); end
            e = exp_q.pop_front(); vec_cnt++;
            if (n_g !== e) begin err_cnt++; $display("FAIL imm_green_idle: got %0d on-slots expected %0d", n_g, e); end
            e = exp_q.pop_front(); vec_cnt++;
            if (n_b !== e) begin err_cnt++; $display("FAIL imm_blue_idle: got %0d on-slots expected %0d", n_b, e); end
        end
        send(2'd0, 8'd0, 1'b0);
    endtask

    task automatic test_broadcast_polarity();
        int n_r, n_g, n_b, n_inv, e;
        send(2'd3, 8'd128, 1'b0);
        @(negedge clk);
        exp_q.push_back(128); exp_q.push_back(128); exp_q.push_back(128); exp_q.push_back(0);
        measure(n_r, n_g, n_b, n_inv);
        e = exp_q.pop_front(); vec_cnt++;
        if (n_r !== e) begin err_cnt++; $display("FAIL bcast_red: got %0d expected %0d", n_r, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (n_g !== e) begin err_cnt++; $display("FAIL bcast_green: got %0d expected %0d", n_g, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (n_b !== e) begin err_cnt++; $display("FAIL bcast_blue: got %0d expected %0d", n_b, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (n_inv !== e) begin err_cnt++; $display("FAIL bcast_polarity: got %0d non-inverse samples expected %0d", n_inv, e); end
    endtask

    task automatic test_fade();
        int a, n, e, lo, hi;
        send(2'd3, 8'd0, 1'b0);
        // Ramp up 0 -> 10.
        send(2'd1, 8'd10, 1'b1);
        a = cyc;
        exp_q.push_back(1);
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL fade_up_busy_rise: got %b expected %0d", busy, e); end
        exp_q.push_back((a / 4 + 1) * 4 + 36 - a); exp_q.push_back(10);
        n = 0;
        while (busy !== 1'b0 && n < 80) begin @(negedge clk); n++; end
        e = exp_q.pop_front(); vec_cnt++;
        if (cyc - a !== e) begin err_cnt++; $display("FAIL fade_up_cycles: got %0d expected %0d", cyc - a, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[1]) !== e) begin err_cnt++; $display("FAIL fade_up_level: got %0d expected %0d", dut.cur[1], e); end
        // Ramp down 10 -> 3.
        send(2'd1, 8'd3, 1'b1);
        a = cyc;
        exp_q.push_back((a / 4 + 1) * 4 + 24 - a); exp_q.push_back(3); exp_q.push_back(3);
        lo = 255; hi = 0; n = 0;
        while (busy !== 1'b0 && n < 80) begin
            @(negedge clk); n++;
            if (int'(dut.cur[1]) < lo) lo = int'(dut.cur[1]);
            if (int'(dut.cur[1]) > hi) hi = int'(dut.cur[1]);
        end
        e = exp_q.pop_front(); vec_cnt++;
        if (cyc - a !== e) begin err_cnt++; $display("FAIL fade_down_cycles: got %0d expected %0d", cyc - a, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[1]) !== e) begin err_cnt++; $display("FAIL fade_down_level: got %0d expected %0d", dut.cur[1], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (lo !== e) begin err_cnt++; $display("FAIL fade_down_min: got %0d expected %0d", lo, e); end
    endtask

    task automatic test_collision();
        int a, t, n, e;
        send(2'd3, 8'd0, 1'b0);
        send(2'd3, 8'd50, 1'b1);
        a = cyc;
        n = 0;
        while (!(cyc % 4 == 3 && cyc >= a + 8) && n < 20) begin @(negedge clk); n++; end
        // The next edge is a fade tick; the command to red lands on it.
        send(2'd0, 8'd200, 1'b1);
        t = cyc;
        exp_q.push_back(ticks(a, t - 1)); exp_q.push_back(ticks(a, t)); exp_q.push_back(ticks(a, t));
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[0]) !== e) begin err_cnt++; $display("FAIL collide_red_held: got %0d expected %0d", dut.cur[0], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[1]) !== e) begin err_cnt++; $display("FAIL collide_green_step: got %0d expected %0d", dut.cur[1], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[2]) !== e) begin err_cnt++; $display("FAIL collide_blue_step: got %0d expected %0d", dut.cur[2], e); end
    endtask

    task automatic test_reversal();
        int a, n, e, hi;
        send(2'd3, 8'd0, 1'b0);
        send(2'd0, 8'd5, 1'b0);
        send(2'd0, 8'd200, 1'b1);
        n = 0;
        while (dut.cur[0] !== 8'd7 && n < 20) begin @(negedge clk); n++; end
        send(2'd0, 8'd0, 1'b1);
        a = cyc;
        exp_q.push_back(7); exp_q.push_back((a / 4 + 1) * 4 + 24 - a); exp_q.push_back(0);
        hi = int'(dut.cur[0]); n = 0;
        while (busy !== 1'b0 && n < 80) begin
            @(negedge clk); n++;
            if (int'(dut.cur[0]) > hi) hi = int'(dut.cur[0]);
        end
        e = exp_q.pop_front(); vec_cnt++;
        if (hi !== e) begin err_cnt++; $display("FAIL reverse_peak: got %0d expected %0d", hi, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (cyc - a !== e) begin err_cnt++; $display("FAIL reverse_cycles: got %0d expected %0d", cyc - a, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[0]) !== e) begin err_cnt++; $display("FAIL reverse_level: got %0d expected %0d", dut.cur[0], e); end
        repeat (12) @(negedge clk);
        exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if (int'({busy, dut.cur[0]}) !== e) begin err_cnt++; $display("FAIL reverse_floor: got busy/cur %0h expected %0d", {busy, dut.cur[0]}, e); end
    endtask

    task automatic test_back_to_back();
        int e;
        send(2'd0, 8'd10, 1'b0);
        send(2'd1, 8'd20, 1'b0);
        send(2'd2, 8'd30, 1'b0);
        exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30); exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[0]) !== e) begin err_cnt++; $display("FAIL b2b_red: got %0d expected %0d", dut.cur[0], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[1]) !== e) begin err_cnt++; $display("FAIL b2b_green: got %0d expected %0d", dut.cur[1], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur[2]) !== e) begin err_cnt++; $display("FAIL b2b_blue: got %0d expected %0d", dut.cur[2], e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL b2b_busy: got %b expected %0d", busy, e); end
    endtask

    task automatic test_reset_mid_ramp();
        int e;
        send(2'd3, 8'd255, 1'b1);
        repeat (20) @(negedge clk);
        exp_q.push_back(1);
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL midramp_busy: got %b expected %0d", busy, e); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(int'(INV)); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if ({led_blue, led_green, led_red} !== 3'(e)) begin err_cnt++;
            $display("FAIL async_rst_pins: got %b expected %b", {led_blue, led_green, led_red}, 3'(e)); end
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL async_rst_busy: got %b expected %0d", busy, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (cmd_ready !== 1'(e)) begin err_cnt++; $display("FAIL async_rst_ready: got %b expected %0d", cmd_ready, e); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.cur) !== e) begin err_cnt++; $display("FAIL post_rst_cur: got %h expected %0d", dut.cur, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (int'(dut.tgt) !== e) begin err_cnt++; $display("FAIL post_rst_tgt: got %h expected %0d", dut.tgt, e); end
        e = exp_q.pop_front(); vec_cnt++;
        if (busy !== 1'(e)) begin err_cnt++; $display("FAIL post_rst_busy: got %b expected %0d", busy, e); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_broadcast_polarity();
        test_fade();
        test_collision();
        test_reversal();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
